// File: rtl/lbm_pkg.sv
// Shared LBM types: Q3.13 word, D2Q9 direction indices, AXIS widths, tx FSM state.
// COLLIDER_TX_MACRO_EN adds rho/u_x/u_y to each transmitted cell (6 beats instead of 5).
package lbm_pkg;

  localparam int Q_W = 16;
  typedef logic signed [Q_W-1:0] q3_13_t;

  localparam int DIR_NULL = 0;
  localparam int DIR_N    = 1;
  localparam int DIR_NE   = 2;
  localparam int DIR_E    = 3;
  localparam int DIR_SE   = 4;
  localparam int DIR_S    = 5;
  localparam int DIR_SW   = 6;
  localparam int DIR_W    = 7;
  localparam int DIR_NW   = 8;
  localparam int NDIR     = 9;

  typedef logic [NDIR-1:0][Q_W-1:0] pop_vec_t;

  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;

`ifdef COLLIDER_TX_MACRO_EN
  localparam int NBEATS = 6;
`else
  localparam int NBEATS = 5;
`endif
  localparam int BEAT_W = 3;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/collider_axis_tx_if.sv
// AXI4-Stream bus carrying packed collider results toward the DMA S2MM channel.
interface collider_axis_tx_if;
  import lbm_pkg::*;

  logic [AXIS_DATA_W-1:0] tdata;
  logic [AXIS_KEEP_W-1:0] tkeep;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic                   tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );

endinterface

// File: rtl/collider_tx_packer.sv
// Beat index -> {hi, lo} word pair and byte enables for one buffered cell.
// With COLLIDER_TX_MACRO_EN beat 4 carries rho and beat 5 carries {u_y, u_x}.
module collider_tx_packer
  import lbm_pkg::*;
(
  input  logic                   active,
  input  logic [BEAT_W-1:0]      beat,
  input  pop_vec_t               pops,
`ifdef COLLIDER_TX_MACRO_EN
  input  q3_13_t                 rho,
  input  q3_13_t                 u_x,
  input  q3_13_t                 u_y,
`endif
  output logic [AXIS_DATA_W-1:0] tdata,
  output logic [AXIS_KEEP_W-1:0] tkeep
);

  // Outputs are forced to zero outside SEND so the bus reads clean while idle or in reset.
  always_comb begin
    tdata = '0;
    tkeep = '0;
    if (active) begin
      tkeep = 4'hF;
      case (beat)
        3'd0: tdata = {pops[DIR_N],  pops[DIR_NULL]};
        3'd1: tdata = {pops[DIR_E],  pops[DIR_NE]};
        3'd2: tdata = {pops[DIR_S],  pops[DIR_SE]};
        3'd3: tdata = {pops[DIR_W],  pops[DIR_SW]};
`ifdef COLLIDER_TX_MACRO_EN
        3'd4: tdata = {rho, pops[DIR_NW]};
        3'd5: tdata = {u_y, u_x};
`else
        3'd4: begin
          tdata = {16'h0000, pops[DIR_NW]};
          tkeep = 4'h3;
        end
`endif
        default: begin
          tdata = '0;
          tkeep = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/collider_axis_tx.sv
// Captures one post-collision cell per handshake and streams it as 32-bit AXIS beats.
// Define COLLIDER_TX_MACRO_EN to also send rho/u_x/u_y (6 beats per cell instead of 5).
module collider_axis_tx
  import lbm_pkg::*;
#(
  parameter int CELLS_PER_FRAME = 64,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  q3_13_t              f_null,
  input  q3_13_t              f_n,
  input  q3_13_t              f_ne,
  input  q3_13_t              f_e,
  input  q3_13_t              f_se,
  input  q3_13_t              f_s,
  input  q3_13_t              f_sw,
  input  q3_13_t              f_w,
  input  q3_13_t              f_nw,
  input  q3_13_t              rho,
  input  q3_13_t              u_x,
  input  q3_13_t              u_y,
  collider_axis_tx_if.master  m_axis,
  output logic [CNT_W-1:0]    frames_sent,
  output logic                tx_busy
);

  localparam logic [CNT_W-1:0]  CELL_LAST = CNT_W'(CELLS_PER_FRAME - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NBEATS - 1);

  tx_state_t              state_q;
  tx_state_t              state_d;
  logic [BEAT_W-1:0]      beat_cnt;
  logic [CNT_W-1:0]       cell_cnt;
  logic [CNT_W-1:0]       frame_cnt;
  pop_vec_t               pop_p0;
  logic                   sending;
  logic                   tvalid;
  logic                   capture;
  logic                   beat_done;
  logic                   last_beat;
  logic                   last_cell;
  logic [AXIS_DATA_W-1:0] tdata;
  logic [AXIS_KEEP_W-1:0] tkeep;

`ifdef COLLIDER_TX_MACRO_EN
  q3_13_t rho_p0;
  q3_13_t u_x_p0;
  q3_13_t u_y_p0;
`else
  logic unused_macro_in;
  assign unused_macro_in = ^{rho, u_x, u_y};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= TX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    tvalid   = 1'b0;
    sending  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = TX_SEND;
      end
      TX_SEND: begin
        tvalid  = 1'b1;
        sending = 1'b1;
        if (m_axis.tready && (beat_cnt == BEAT_LAST)) state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  assign capture   = in_valid && in_ready;
  assign beat_done = tvalid && m_axis.tready;
  assign last_beat = (beat_cnt == BEAT_LAST);
  assign last_cell = (cell_cnt == CELL_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      cell_cnt  <= '0;
      frame_cnt <= '0;
    end else if (capture) begin
      beat_cnt <= '0;
    end else if (beat_done) begin
      if (last_beat) begin
        beat_cnt <= '0;
        if (last_cell) begin
          cell_cnt  <= '0;
          frame_cnt <= frame_cnt + CNT_W'(1);
        end else begin
          cell_cnt <= cell_cnt + CNT_W'(1);
        end
      end else begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  // Stage p0: cell buffer, loaded only on the input handshake; data needs no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      pop_p0[DIR_NULL] <= f_null;
      pop_p0[DIR_N]    <= f_n;
      pop_p0[DIR_NE]   <= f_ne;
      pop_p0[DIR_E]    <= f_e;
      pop_p0[DIR_SE]   <= f_se;
      pop_p0[DIR_S]    <= f_s;
      pop_p0[DIR_SW]   <= f_sw;
      pop_p0[DIR_W]    <= f_w;
      pop_p0[DIR_NW]   <= f_nw;
`ifdef COLLIDER_TX_MACRO_EN
      rho_p0           <= rho;
      u_x_p0           <= u_x;
      u_y_p0           <= u_y;
`endif
    end
  end

  collider_tx_packer u_packer (
    .active (sending),
    .beat   (beat_cnt),
    .pops   (pop_p0),
`ifdef COLLIDER_TX_MACRO_EN
    .rho    (rho_p0),
    .u_x    (u_x_p0),
    .u_y    (u_y_p0),
`endif
    .tdata  (tdata),
    .tkeep  (tkeep)
  );

  assign m_axis.tdata  = tdata;
  assign m_axis.tkeep  = tkeep;
  assign m_axis.tvalid = tvalid;
  assign m_axis.tlast  = sending && last_beat && last_cell;
  assign m_axis.tuser  = sending && (beat_cnt == '0) && (cell_cnt == '0);
  assign frames_sent   = frame_cnt;
  assign tx_busy       = sending;

endmodule

// File: tb/tb_collider_axis_tx.sv
// Randomised bench: two transmitters (4 and 1 cells per frame) checked against a cell-level model.
module tb_collider_axis_tx;
  import lbm_pkg::*;

`ifdef COLLIDER_TX_MACRO_EN
  localparam int NB = 6;
`else
  localparam int NB = 5;
`endif
  localparam int CPF_A = 4;
  localparam int CPF_B = 1;

  typedef struct packed {
    logic [15:0]       rho;
    logic [15:0]       ux;
    logic [15:0]       uy;
    logic [8:0][15:0]  f;
  } cell_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic tready = 1'b1;
  cell_t cur = '0;
  logic in_ready_a, in_ready_b, busy_a, busy_b;
  logic [15:0] frames_a, frames_b;

  int n_cmp = 0;
  int n_err = 0;
  int cells_done = 0;

  logic [31:0] g_data [8];
  logic [3:0]  g_keep [8];
  logic        g_user_a [8];
  logic        g_last_a [8];
  logic        g_user_b [8];
  logic        g_last_b [8];
  int          g_cnt, g_stab, g_rdy;
  bit          g_tmo;
  logic        pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  collider_axis_tx_if ax_a ();
  collider_axis_tx_if ax_b ();
  assign ax_a.tready = tready;
  assign ax_b.tready = tready;

  collider_axis_tx #(.CELLS_PER_FRAME(CPF_A), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .f_null(cur.f[0]), .f_n(cur.f[1]), .f_ne(cur.f[2]), .f_e(cur.f[3]), .f_se(cur.f[4]),
    .f_s(cur.f[5]), .f_sw(cur.f[6]), .f_w(cur.f[7]), .f_nw(cur.f[8]),
    .rho(cur.rho), .u_x(cur.ux), .u_y(cur.uy),
    .m_axis(ax_a), .frames_sent(frames_a), .tx_busy(busy_a)
  );

  collider_axis_tx #(.CELLS_PER_FRAME(CPF_B), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .f_null(cur.f[0]), .f_n(cur.f[1]), .f_ne(cur.f[2]), .f_e(cur.f[3]), .f_se(cur.f[4]),
    .f_s(cur.f[5]), .f_sw(cur.f[6]), .f_w(cur.f[7]), .f_nw(cur.f[8]),
    .rho(cur.rho), .u_x(cur.ux), .u_y(cur.uy),
    .m_axis(ax_b), .frames_sent(frames_b), .tx_busy(busy_b)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Cell-level reference model.
  function automatic logic [31:0] exp_data(cell_t c, int b);
    case (b)
      0: return {c.f[1], c.f[0]};
      1: return {c.f[3], c.f[2]};
      2: return {c.f[5], c.f[4]};
      3: return {c.f[7], c.f[6]};
`ifdef COLLIDER_TX_MACRO_EN
      4: return {c.rho, c.f[8]};
      5: return {c.uy, c.ux};
`else
      4: return {16'h0000, c.f[8]};
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] exp_keep(int b);
`ifdef COLLIDER_TX_MACRO_EN
    return (b < NB) ? 4'hF : 4'h0;
`else
    return (b == 4) ? 4'h3 : 4'hF;
`endif
  endfunction

  function automatic logic exp_user(int idx, int cpf, int b);
    return (b == 0) && (idx % cpf == 0);
  endfunction

  function automatic logic exp_last(int idx, int cpf, int b);
    return (b == NB - 1) && (idx % cpf == cpf - 1);
  endfunction

  function automatic cell_t rand_cell();
    cell_t c;
    for (int i = 0; i < 9; i++) c.f[i] = 16'($urandom);
    c.rho = 16'($urandom);
    c.ux  = 16'($urandom);
    c.uy  = 16'($urandom);
    return c;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cells_done = 0;
  endtask

  // Hands one cell to both DUTs and records every accepted beat (mode 1 = tready pattern 1,0,0,1,0).
  task automatic send_cell(input cell_t c, input int mode);
    int acc, ph, cyc;
    bit hold;
    logic [31:0] pd;
    logic [3:0] pk;
    logic pl, pu;
    acc = 0; ph = 0; cyc = 0; hold = 0; pd = '0; pk = '0; pl = 0; pu = 0;
    g_stab = 0; g_rdy = 0; g_tmo = 0;
    for (int w = 0; w < 20 && in_ready_a !== 1'b1; w++) @(negedge clk);
    cur = c;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (acc < NB && cyc < 80) begin
      if (hold && (ax_a.tvalid !== 1'b1 || ax_a.tdata !== pd || ax_a.tkeep !== pk ||
                   ax_a.tlast !== pl || ax_a.tuser !== pu)) g_stab++;
      if (ax_a.tvalid === 1'b1 && in_ready_a !== 1'b0) g_rdy++;
      tready = (mode == 0) ? 1'b1 : pat[ph % 5];
      ph++;
      if (ax_a.tvalid === 1'b1 && tready) begin
        g_data[acc] = ax_a.tdata;  g_keep[acc] = ax_a.tkeep;
        g_user_a[acc] = ax_a.tuser; g_last_a[acc] = ax_a.tlast;
        g_user_b[acc] = ax_b.tuser; g_last_b[acc] = ax_b.tlast;
        acc++;
        hold = 0;
      end else begin
        hold = (ax_a.tvalid === 1'b1);
        pd = ax_a.tdata; pk = ax_a.tkeep; pl = ax_a.tlast; pu = ax_a.tuser;
      end
      @(negedge clk);
      cyc++;
    end
    g_cnt = acc;
    g_tmo = (acc < NB);
    tready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready_a !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready_a); end
    n_cmp++; if (ax_a.tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid got %b want 0", ax_a.tvalid); end
    n_cmp++; if (ax_a.tlast !== 1'b0 || ax_a.tuser !== 1'b0) begin n_err++; $display("FAIL reset_flags got last=%b user=%b want 0 0", ax_a.tlast, ax_a.tuser); end
    n_cmp++; if (ax_a.tdata !== 32'h0 || ax_a.tkeep !== 4'h0) begin n_err++; $display("FAIL reset_bus got data=%h keep=%h want 0 0", ax_a.tdata, ax_a.tkeep); end
    n_cmp++; if (frames_a !== 16'h0 || busy_a !== 1'b0) begin n_err++; $display("FAIL reset_ctr got frames=%h busy=%b want 0 0", frames_a, busy_a); end
    in_valid = 1'b0;
    rst = 1'b0;
    cells_done = 0;
  endtask

  task automatic test_basic_cell();
    cell_t c;
    c = '0;
    c.f[0] = 16'h0E39;
    for (int i = 1; i < 9; i++) c.f[i] = 16'h0100 + 16'(i);
    c.rho = 16'h2000; c.ux = 16'h0100; c.uy = 16'hFF00;
    send_cell(c, 0);
    n_cmp++; if (g_tmo) begin n_err++; $display("FAIL basic_timeout got %0d beats want %0d", g_cnt, NB); end
    n_cmp++; if (g_data[0] !== 32'h0101_0E39) begin n_err++; $display("FAIL basic_beat0 got %h want 01010e39", g_data[0]); end
    for (int b = 0; b < NB; b++) begin
      n_cmp++; if (g_data[b] !== exp_data(c, b)) begin n_err++; $display("FAIL basic_data[%0d] got %h want %h", b, g_data[b], exp_data(c, b)); end
      n_cmp++; if (g_keep[b] !== exp_keep(b)) begin n_err++; $display("FAIL basic_keep[%0d] got %h want %h", b, g_keep[b], exp_keep(b)); end
      n_cmp++; if (g_user_b[b] !== exp_user(cells_done, CPF_B, b) || g_last_b[b] !== exp_last(cells_done, CPF_B, b)) begin
        n_err++; $display("FAIL basic_flags_b[%0d] got user=%b last=%b", b, g_user_b[b], g_last_b[b]); end
      n_cmp++; if (g_user_a[b] !== exp_user(cells_done, CPF_A, b) || g_last_a[b] !== exp_last(cells_done, CPF_A, b)) begin
        n_err++; $display("FAIL basic_flags_a[%0d] got user=%b last=%b", b, g_user_a[b], g_last_a[b]); end
    end
    cells_done++;
    n_cmp++; if (frames_b !== 16'(cells_done)) begin n_err++; $display("FAIL basic_frames_b got %0d want %0d", frames_b, cells_done); end
    n_cmp++; if (frames_a !== 16'(cells_done / CPF_A)) begin n_err++; $display("FAIL basic_frames_a got %0d want %0d", frames_a, cells_done / CPF_A); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 3; k++) begin
      cell_t c;
      c = rand_cell();
      send_cell(c, 1);
      n_cmp++; if (g_cnt !== NB) begin n_err++; $display("FAIL bp_handshakes got %0d want %0d", g_cnt, NB); end
      n_cmp++; if (g_stab !== 0) begin n_err++; $display("FAIL bp_stability got %0d unstable stalls want 0", g_stab); end
      n_cmp++; if (g_rdy !== 0) begin n_err++; $display("FAIL bp_in_ready got %0d cycles high in SEND want 0", g_rdy); end
      n_cmp++; if (ax_a.tvalid !== 1'b0) begin n_err++; $display("FAIL bp_extra_beat got tvalid=%b want 0", ax_a.tvalid); end
      for (int b = 0; b < g_cnt; b++) begin
        n_cmp++; if (g_data[b] !== exp_data(c, b) || g_keep[b] !== exp_keep(b)) begin
          n_err++; $display("FAIL bp_beat[%0d] got %h/%h want %h/%h", b, g_data[b], g_keep[b], exp_data(c, b), exp_keep(b)); end
      end
      cells_done++;
    end
  endtask

  task automatic test_frame_boundary();
    reset_dut();
    for (int k = 0; k < 8; k++) begin
      cell_t c;
      c = rand_cell();
      send_cell(c, k % 2);
      n_cmp++; if (g_tmo) begin n_err++; $display("FAIL frame_timeout cell %0d got %0d beats want %0d", k, g_cnt, NB); end
      for (int b = 0; b < g_cnt; b++) begin
        n_cmp++; if (g_user_a[b] !== exp_user(cells_done, CPF_A, b) || g_last_a[b] !== exp_last(cells_done, CPF_A, b)) begin
          n_err++; $display("FAIL frame_flags_a cell %0d beat %0d got user=%b last=%b want %b %b", k, b,
                            g_user_a[b], g_last_a[b], exp_user(cells_done, CPF_A, b), exp_last(cells_done, CPF_A, b)); end
        n_cmp++; if (g_user_b[b] !== exp_user(cells_done, CPF_B, b) || g_last_b[b] !== exp_last(cells_done, CPF_B, b)) begin
          n_err++; $display("FAIL frame_flags_b cell %0d beat %0d got user=%b last=%b", k, b, g_user_b[b], g_last_b[b]); end
        n_cmp++; if (g_data[b] !== exp_data(c, b)) begin n_err++; $display("FAIL frame_data cell %0d beat %0d got %h want %h", k, b, g_data[b], exp_data(c, b)); end
      end
      cells_done++;
    end
    n_cmp++; if (frames_a !== 16'd2) begin n_err++; $display("FAIL frame_count_a got %0d want 2", frames_a); end
    n_cmp++; if (frames_b !== 16'd8) begin n_err++; $display("FAIL frame_count_b got %0d want 8", frames_b); end
  endtask

  task automatic test_reset_mid_frame();
    cell_t c0, c1, c2;
    reset_dut();
    c0 = rand_cell(); c1 = rand_cell(); c2 = rand_cell();
    send_cell(c0, 0);
    cells_done++;
    for (int w = 0; w < 20 && in_ready_a !== 1'b1; w++) @(negedge clk);
    cur = c1; in_valid = 1'b1; tready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    tready = 1'b0;
    n_cmp++; if (ax_a.tvalid !== 1'b1 || ax_a.tdata !== exp_data(c1, 2)) begin
      n_err++; $display("FAIL rstmid_beat2 got v=%b %h want 1 %h", ax_a.tvalid, ax_a.tdata, exp_data(c1, 2)); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (ax_a.tvalid !== 1'b0 || ax_b.tvalid !== 1'b0) begin n_err++; $display("FAIL rstmid_tvalid got %b/%b want 0", ax_a.tvalid, ax_b.tvalid); end
    n_cmp++; if (in_ready_a !== 1'b1 || busy_a !== 1'b0) begin n_err++; $display("FAIL rstmid_ctrl got ready=%b busy=%b want 1 0", in_ready_a, busy_a); end
    n_cmp++; if (frames_a !== 16'h0 || frames_b !== 16'h0) begin n_err++; $display("FAIL rstmid_frames got %0d/%0d want 0", frames_a, frames_b); end
    n_cmp++; if (ax_a.tdata !== 32'h0 || ax_a.tlast !== 1'b0) begin n_err++; $display("FAIL rstmid_bus got %h last=%b want 0", ax_a.tdata, ax_a.tlast); end
    @(negedge clk);
    rst = 1'b0;
    tready = 1'b1;
    cells_done = 0;
    send_cell(c2, 0);
    n_cmp++; if (g_tmo) begin n_err++; $display("FAIL rstmid_timeout got %0d beats want %0d", g_cnt, NB); end
    n_cmp++; if (g_user_a[0] !== 1'b1 || g_user_b[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_tuser got %b/%b want 1", g_user_a[0], g_user_b[0]); end
    for (int b = 0; b < g_cnt; b++) begin
      n_cmp++; if (g_data[b] !== exp_data(c2, b)) begin n_err++; $display("FAIL rstmid_data[%0d] got %h want %h", b, g_data[b], exp_data(c2, b)); end
    end
    cells_done++;
  endtask

  task automatic test_throughput();
    cell_t cl [10];
    int cap_cyc [10];
    logic [31:0] bd [$];
    int bc [$];
    logic ua [$];
    logic la [$];
    logic lb [$];
    int ncap, cyc, base, nchk;
    bit pend;
    ncap = 0; cyc = 0; pend = 0; base = cells_done;
    for (int i = 0; i < 10; i++) begin cl[i] = rand_cell(); cap_cyc[i] = -1; end
    for (int w = 0; w < 20 && in_ready_a !== 1'b1; w++) @(negedge clk);
    tready = 1'b1;
    cur = cl[0];
    in_valid = 1'b1;
    while (cyc < 300 && bd.size() < 10 * NB) begin
      if (pend) begin
        if (ncap < 10) cur = cl[ncap];
        else in_valid = 1'b0;
        pend = 0;
      end
      if (ax_a.tvalid === 1'b1) begin
        bd.push_back(ax_a.tdata); bc.push_back(cyc);
        ua.push_back(ax_a.tuser); la.push_back(ax_a.tlast); lb.push_back(ax_b.tlast);
      end
      if (in_valid && in_ready_a === 1'b1) begin
        if (ncap < 10) cap_cyc[ncap] = cyc;
        ncap++;
        pend = 1;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (ncap !== 10) begin n_err++; $display("FAIL tput_captures got %0d want 10", ncap); end
    n_cmp++; if (bd.size() !== 10 * NB) begin n_err++; $display("FAIL tput_beats got %0d want %0d", bd.size(), 10 * NB); end
    for (int i = 1; i < 10; i++) begin
      n_cmp++; if (cap_cyc[i] - cap_cyc[i-1] !== NB + 1) begin
        n_err++; $display("FAIL tput_interval[%0d] got %0d want %0d", i, cap_cyc[i] - cap_cyc[i-1], NB + 1); end
    end
    nchk = (bd.size() < 10 * NB) ? bd.size() : 10 * NB;
    for (int k = 0; k < nchk; k++) begin
      int ci, b;
      ci = k / NB; b = k % NB;
      n_cmp++; if (bd[k] !== exp_data(cl[ci], b)) begin n_err++; $display("FAIL tput_data cell %0d beat %0d got %h want %h", ci, b, bd[k], exp_data(cl[ci], b)); end
      n_cmp++; if (bc[k] !== cap_cyc[ci] + 1 + b) begin n_err++; $display("FAIL tput_timing cell %0d beat %0d got cycle %0d want %0d", ci, b, bc[k], cap_cyc[ci] + 1 + b); end
      n_cmp++; if (ua[k] !== exp_user(base + ci, CPF_A, b) || la[k] !== exp_last(base + ci, CPF_A, b) || lb[k] !== exp_last(base + ci, CPF_B, b)) begin
        n_err++; $display("FAIL tput_flags cell %0d beat %0d got user_a=%b last_a=%b last_b=%b", ci, b, ua[k], la[k], lb[k]); end
    end
    cells_done += 10;
    n_cmp++; if (frames_a !== 16'(cells_done / CPF_A)) begin n_err++; $display("FAIL tput_frames_a got %0d want %0d", frames_a, cells_done / CPF_A); end
    n_cmp++; if (frames_b !== 16'(cells_done)) begin n_err++; $display("FAIL tput_frames_b got %0d want %0d", frames_b, cells_done); end
  endtask

  initial begin
    test_reset();
    test_basic_cell();
    test_backpressure();
    test_frame_boundary();
    test_reset_mid_frame();
    test_throughput();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
